// File: rtl/imem_boot_arb.sv
// imem_boot_arb: boot loader packing loader bytes into 16-bit words
// written to instruction RAM from address 0, then fetch arbiter.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   ld_valid/ready/data/last loader byte stream (high byte first)
//   reload                  restart loading at address 0
//   fetch_req/addr          CPU fetch request in RUN
//   fetch_data/valid        registered fetch result, 1-cycle latency
//   cpu_hold                CPU held while not in RUN
//   load_done               one-cycle pulse on entry to RUN
//   words_loaded            words written by the last load
//   mem_addr/data/we        RAM write/read port
//   mem_dout                RAM combinational read data
module imem_boot_arb #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  input  logic                  reload,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DWIDTH-1:0]     fetch_data,
  output logic                  fetch_valid,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0]     mem_data,
  output logic                  mem_we,
  input  logic [DWIDTH-1:0]     mem_dout
);

  typedef enum logic [1:0] {
    LOAD_HI,
    LOAD_LO,
    WRITE,
    RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [7:0]            hi_byte;
  logic [7:0]            lo_byte;
  logic                  last_q;

  logic accept;
  logic at_top;
  logic finish;

  assign accept = ld_valid & ld_ready;

  // Last RAM word: the load ends here even without ld_last.
  assign at_top = (wr_ptr == {ADDR_WIDTH{1'b1}});
  assign finish = last_q | at_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_HI;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ld_ready = 1'b0;
    mem_we   = 1'b0;
    cpu_hold = 1'b1;
    unique case (state)
      LOAD_HI: begin
        ld_ready = ~reload;
        if (accept) begin
          state_nx = ld_last ? WRITE : LOAD_LO;
        end
      end
      LOAD_LO: begin
        ld_ready = ~reload;
        if (accept) begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        // A reload sampled in WRITE suppresses the write.
        mem_we   = ~reload;
        state_nx = finish ? RUN : LOAD_HI;
      end
      RUN: begin
        cpu_hold = 1'b0;
      end
      default: begin
        state_nx = LOAD_HI;
      end
    endcase
    if (reload) begin
      state_nx = LOAD_HI;
    end
  end

  assign mem_addr = (state == RUN) ? fetch_addr : wr_ptr;
  assign mem_data = mem_we ? {hi_byte, lo_byte} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      hi_byte      <= '0;
      lo_byte      <= '0;
      last_q       <= 1'b0;
      words_loaded <= '0;
      load_done    <= 1'b0;
      fetch_valid  <= 1'b0;
      fetch_data   <= '0;
    end else begin
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      if (reload) begin
        wr_ptr <= '0;
        last_q <= 1'b0;
      end else begin
        unique case (state)
          LOAD_HI: begin
            if (accept) begin
              hi_byte <= ld_data;
              last_q  <= ld_last;
              // Odd-length program: pad the final word.
              if (ld_last) begin
                lo_byte <= 8'h00;
              end
            end
          end
          LOAD_LO: begin
            if (accept) begin
              lo_byte <= ld_data;
              last_q  <= ld_last;
            end
          end
          WRITE: begin
            words_loaded <= {1'b0, wr_ptr} + 1'b1;
            if (finish) begin
              load_done <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
          RUN: begin
            if (fetch_req) begin
              fetch_valid <= 1'b1;
              fetch_data  <= mem_dout;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
